// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the 8-bit CPU: fetches 16-bit instructions,
// sequences FETCH/DECODE/EXEC/WB and drives ALU_OP, register-file controls and the PC.
module cpu_ctrl_fsm #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [15:0]      imem_data,
  input  logic             b_pcsrc,
  output logic [6:0]       alu_op,
  output logic [2:0]       rs0_addr,
  output logic [2:0]       rs1_addr,
  output logic             imm_sel,
  output logic [7:0]       imm,
  output logic [2:0]       rd_addr,
  output logic             rf_we,
  output logic             wb_sel,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [6:0] ALU_IDLE   = 7'h70;
  localparam logic [2:0] FUN_CAL    = 3'd0;
  localparam logic [2:0] FUN_IMM    = 3'd1;
  localparam logic [2:0] FUN_BRANCH = 3'd2;
  localparam logic [2:0] FUN_BJUMP  = 3'd3;
  localparam logic [2:0] FUN_HALT   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       alu_op_q, alu_op_d;
  logic [2:0]       rs0_q, rs0_d, rs1_q, rs1_d, rd_q, rd_d;
  logic [7:0]       imm_q, imm_d;
  logic             imm_sel_q, imm_sel_d;
  logic             wb_sel_q, wb_sel_d;
  logic             rf_we_q, rf_we_d;
  logic             req_q, req_d;
  logic             halted_q, halted_d;

  // Current-instruction decode (from the latched IR)
  logic [2:0]      fun_c;
  logic [1:0]      op_c;
  logic            is_jal_c, is_cond_c, is_nop_c, writes_c;
  logic [PC_W-1:0] offset_c;
  // Decode of the IR value about to be held (drives operand registers)
  logic [2:0]      fun_n_c;
  logic [1:0]      op_n_c;

  always_comb begin
    fun_c     = ir_q[15:13];
    op_c      = ir_q[12:11];
    is_jal_c  = (fun_c == FUN_BJUMP) && (op_c == 2'd0);
    is_cond_c = (fun_c == FUN_BRANCH) || ((fun_c == FUN_BJUMP) && (op_c != 2'd0));
    is_nop_c  = (fun_c == 3'd4) || (fun_c == 3'd5) || (fun_c == 3'd6);
    writes_c  = (fun_c == FUN_CAL) || (fun_c == FUN_IMM) || is_jal_c;
    offset_c  = is_jal_c ? PC_W'($signed(ir_q[5:0])) : PC_W'($signed(ir_q[2:0]));
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    taken_d = taken_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (imem_valid) begin
          state_d = S_DECODE;
          ir_d    = imem_data;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_jal_c)       taken_d = 1'b1;
        else if (is_cond_c) taken_d = b_pcsrc;
        else                taken_d = 1'b0;
        if (fun_c == FUN_HALT) begin
          state_d = S_HALT;
          taken_d = 1'b0;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        pc_d    = taken_q ? (pc_q + offset_c) : (pc_q + PC_W'(1));
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase

    fun_n_c   = ir_d[15:13];
    op_n_c    = ir_d[12:11];
    rd_d      = ir_d[8:6];
    rs0_d     = ir_d[5:3];
    rs1_d     = ir_d[2:0];
    imm_sel_d = (fun_n_c == FUN_IMM) || ((fun_n_c == FUN_CAL) && (op_n_c == 2'd3));
    imm_d     = imm_sel_d ? {5'd0, ir_d[2:0]} : 8'h00;
    wb_sel_d  = (fun_n_c == FUN_BJUMP) && (op_n_c == 2'd0);
    if ((fun_n_c == FUN_BRANCH) || ((fun_n_c == FUN_BJUMP) && (op_n_c != 2'd0))) begin
      rs0_d = ir_d[8:6];
      rs1_d = ir_d[5:3];
    end

    req_d    = (state_d == S_FETCH);
    halted_d = (state_d == S_HALT);
    rf_we_d  = (state_d == S_WB) && writes_c;
    alu_op_d = (((state_d == S_EXEC) || (state_d == S_WB)) && !is_nop_c) ? ir_q[15:9] : ALU_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      pc_q      <= '0;
      taken_q   <= 1'b0;
      cnt_q     <= '0;
      alu_op_q  <= ALU_IDLE;
      rs0_q     <= '0;
      rs1_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      imm_sel_q <= 1'b0;
      wb_sel_q  <= 1'b0;
      rf_we_q   <= 1'b0;
      req_q     <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      taken_q   <= taken_d;
      cnt_q     <= cnt_d;
      alu_op_q  <= alu_op_d;
      rs0_q     <= rs0_d;
      rs1_q     <= rs1_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      imm_sel_q <= imm_sel_d;
      wb_sel_q  <= wb_sel_d;
      rf_we_q   <= rf_we_d;
      req_q     <= req_d;
      halted_q  <= halted_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign alu_op    = alu_op_q;
  assign rs0_addr  = rs0_q;
  assign rs1_addr  = rs1_q;
  assign rd_addr   = rd_q;
  assign imm       = imm_q;
  assign imm_sel   = imm_sel_q;
  assign wb_sel    = wb_sel_q;
  assign rf_we     = rf_we_q;
  assign halted    = halted_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: walks a hand-encoded program through the
// control unit and checks each phase against hand-computed values.
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic        b_pcsrc;
  logic [6:0]  alu_op;
  logic [2:0]  rs0_addr, rs1_addr, rd_addr;
  logic        imm_sel;
  logic [7:0]  imm;
  logic        rf_we, wb_sel, halted;
  logic [7:0]  pc;
  logic [15:0] instr_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  exp_pc;
  logic [15:0] exp_cnt;

  cpu_ctrl_fsm #(.PC_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .b_pcsrc(b_pcsrc), .alu_op(alu_op),
    .rs0_addr(rs0_addr), .rs1_addr(rs1_addr),
    .imm_sel(imm_sel), .imm(imm), .rd_addr(rd_addr),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc(pc),
    .halted(halted), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one instruction starting at a negedge with the DUT in FETCH.
  task automatic run_instr(input string nm, input logic [15:0] instr, input int stall,
                           input logic bp, input logic [6:0] e_alu,
                           input logic [2:0] e_rs0, input logic [2:0] e_rs1,
                           input logic e_isel, input logic [7:0] e_imm,
                           input logic e_we, input logic [2:0] e_rd,
                           input logic e_wbsel, input logic [7:0] e_pc_next);
    check({nm, ".req"}, 32'(imem_req), 32'd1);
    check({nm, ".addr"}, 32'(imem_addr), 32'(exp_pc));
    for (int i = 0; i < stall; i++) begin
      imem_valid = 1'b0;
      @(negedge clk);
      check({nm, ".stall_req"}, 32'(imem_req), 32'd1);
    end
    imem_valid = 1'b1;
    imem_data  = instr;
    b_pcsrc    = bp;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_data  = 16'hFFFF;
    check({nm, ".dec_alu"}, 32'(alu_op), 32'h70);
    check({nm, ".dec_req"}, 32'(imem_req), 32'd0);
    check({nm, ".rs0"}, 32'(rs0_addr), 32'(e_rs0));
    check({nm, ".rs1"}, 32'(rs1_addr), 32'(e_rs1));
    check({nm, ".imm_sel"}, 32'(imm_sel), 32'(e_isel));
    check({nm, ".imm"}, 32'(imm), 32'(e_imm));
    @(negedge clk);
    check({nm, ".exec_alu"}, 32'(alu_op), 32'(e_alu));
    check({nm, ".exec_we"}, 32'(rf_we), 32'd0);
    @(negedge clk);
    check({nm, ".wb_we"}, 32'(rf_we), 32'(e_we));
    if (e_we) check({nm, ".wb_rd"}, 32'(rd_addr), 32'(e_rd));
    check({nm, ".wb_sel"}, 32'(wb_sel), 32'(e_wbsel));
    check({nm, ".wb_alu"}, 32'(alu_op), 32'(e_alu));
    @(negedge clk);
    exp_pc  = e_pc_next;
    exp_cnt = exp_cnt + 16'd1;
    check({nm, ".next_we"}, 32'(rf_we), 32'd0);
    check({nm, ".pc"}, 32'(pc), 32'(exp_pc));
    check({nm, ".cnt"}, 32'(instr_cnt), 32'(exp_cnt));
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    imem_data  = 16'h0;
    b_pcsrc    = 1'b0;
    exp_pc     = 8'h00;
    exp_cnt    = 16'h0;
    repeat (2) @(negedge clk);
    check("rst.alu", 32'(alu_op), 32'h70);
    check("rst.req", 32'(imem_req), 32'd0);
    check("rst.pc", 32'(pc), 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    check("rst.we", 32'(rf_we), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    //       name     instr     stl bp alu    rs0   rs1   isel imm    we rd    wbs next
    run_instr("add",  16'h0053, 0, 0, 7'h00, 3'd2, 3'd3, 0, 8'h00, 1, 3'd1, 0, 8'h01);
    run_instr("addi", 16'h3925, 0, 0, 7'h1C, 3'd4, 3'd5, 1, 8'h05, 1, 3'd4, 0, 8'h02);
    run_instr("jal1", 16'h614E, 0, 0, 7'h30, 3'd1, 3'd6, 0, 8'h00, 1, 3'd5, 1, 8'h10);
    run_instr("beqT", 16'h4056, 0, 1, 7'h20, 3'd1, 3'd2, 0, 8'h00, 0, 3'd0, 0, 8'h0E);
    run_instr("jal0", 16'h6002, 0, 0, 7'h30, 3'd0, 3'd2, 0, 8'h00, 1, 3'd0, 1, 8'h10);
    run_instr("beqN", 16'h4056, 0, 0, 7'h20, 3'd1, 3'd2, 0, 8'h00, 0, 3'd0, 0, 8'h11);
    run_instr("jalB", 16'h61ED, 0, 0, 7'h30, 3'd5, 3'd5, 0, 8'h00, 1, 3'd7, 1, 8'hFE);
    run_instr("jalW", 16'h6083, 0, 0, 7'h30, 3'd0, 3'd3, 0, 8'h00, 1, 3'd2, 1, 8'h01);
    run_instr("stall",16'h02CA, 5, 0, 7'h01, 3'd1, 3'd2, 0, 8'h00, 1, 3'd3, 0, 8'h02);
    run_instr("nop",  16'h8000, 0, 1, 7'h70, 3'd0, 3'd0, 0, 8'h00, 0, 3'd0, 0, 8'h03);

    // Reset in the middle of EXEC with a stray valid pending
    imem_valid = 1'b1;
    imem_data  = 16'h0053;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    check("mid.exec_alu", 32'(alu_op), 32'h00);
    rst_n      = 1'b0;
    imem_valid = 1'b1;
    #1;
    check("mid.alu", 32'(alu_op), 32'h70);
    check("mid.pc", 32'(pc), 32'd0);
    check("mid.cnt", 32'(instr_cnt), 32'd0);
    check("mid.req", 32'(imem_req), 32'd0);
    check("mid.rs0", 32'(rs0_addr), 32'd0);
    @(negedge clk);
    check("mid.held_req", 32'(imem_req), 32'd0);
    imem_valid = 1'b0;
    rst_n      = 1'b1;
    exp_pc     = 8'h00;
    exp_cnt    = 16'h0;
    @(negedge clk);

    // HALT after reset
    check("halt.req0", 32'(imem_req), 32'd1);
    imem_valid = 1'b1;
    imem_data  = 16'hE000;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    check("halt.exec_alu", 32'(alu_op), 32'h70);
    check("halt.exec_halted", 32'(halted), 32'd0);
    @(negedge clk);
    check("halt.halted", 32'(halted), 32'd1);
    check("halt.req", 32'(imem_req), 32'd0);
    check("halt.cnt", 32'(instr_cnt), 32'd1);
    check("halt.pc", 32'(pc), 32'd0);
    for (int i = 0; i < 4; i++) begin
      imem_valid = (i % 2) == 0;
      imem_data  = 16'h0053;
      @(negedge clk);
      check("halt.stay", 32'(halted), 32'd1);
      check("halt.req_off", 32'(imem_req), 32'd0);
      check("halt.we_off", 32'(rf_we), 32'd0);
    end
    check("halt.cnt_final", 32'(instr_cnt), 32'd1);
    check("halt.alu_idle", 32'(alu_op), 32'h70);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
